// File: rtl/uart_fifo_if.sv
// Byte FIFO handshake bundle: producer/consumer side (master) and FIFO side (slave).
// Status flag signals exist only when UART_FIFO_STATUS_EN is defined.
interface uart_fifo_if #(
  parameter int B = 8,
  parameter int W = 4
);
  logic         wr;
  logic [B-1:0] w_data;
  logic         rd;
  logic [B-1:0] r_data;
  logic         empty;
  logic         full;
  logic         almost_full;
  logic [W:0]   level;
`ifdef UART_FIFO_STATUS_EN
  logic         overflow;
  logic         underflow;
  logic         clr_err;
`endif

  modport master (
    output wr, w_data, rd,
    input  r_data, empty, full, almost_full, level
`ifdef UART_FIFO_STATUS_EN
    , output clr_err
    , input  overflow, underflow
`endif
  );

  modport slave (
    input  wr, w_data, rd,
    output r_data, empty, full, almost_full, level
`ifdef UART_FIFO_STATUS_EN
    , input  clr_err
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO between UART and command interface.
// Define UART_FIFO_STATUS_EN to add sticky overflow/underflow flags with clr_err.
module uart_fifo #(
  parameter int B         = 8,
  parameter int W         = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  uart_fifo_if.slave bus
);
  localparam int         DEPTH    = 2 ** W;
  localparam logic [W:0] FULL_CNT = (W + 1)'(DEPTH);
  localparam logic [W:0] AF_CNT   = (W + 1)'(DEPTH - AF_MARGIN);

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] wp;
  logic [W-1:0] rp;
  logic [W:0]   cnt;
  logic         wr_ok;
  logic         rd_ok;

  // Flags come from the count alone, so wrap-around never aliases full/empty.
  assign bus.empty       = (cnt == '0);
  assign bus.full        = (cnt == FULL_CNT);
  assign bus.almost_full = (cnt >= AF_CNT);
  assign bus.level       = cnt;
  assign bus.r_data      = mem[rp];

  // A full FIFO still takes a write when a pop frees the head slot this cycle.
  assign wr_ok = bus.wr & (~bus.full | bus.rd);
  assign rd_ok = bus.rd & ~bus.empty;

  // NOTE: storage carries no reset; only pointers and count define validity,
  // which keeps the array as plain flops without a reset tree.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= bus.w_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef UART_FIFO_STATUS_EN
  logic ovf_evt;
  logic udf_evt;
  logic overflow_q;
  logic underflow_q;

  assign ovf_evt = bus.wr & bus.full & ~bus.rd;
  assign udf_evt = bus.rd & bus.empty;

  // A new error in the clear cycle wins, so it is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_evt | (overflow_q  & ~bus.clr_err);
      underflow_q <= udf_evt | (underflow_q & ~bus.clr_err);
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
`endif
endmodule
